// File: rtl/hall_sensor_decoder.sv
// BLDC Hall sensor decoder: synchronizes and debounces the 3-bit Hall code, then tracks
// sector, direction, signed position and commutation period, flagging faults and stall.
module hall_sensor_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          h,
  output logic [2:0]          sector,
  output logic                dir,
  output logic                valid,
  output logic                fault,
  output logic                stall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_stb,
  output logic [15:0]         pos
);

  localparam int unsigned         CNT_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_FAULT} state_t;

  function automatic logic [2:0] decode(input logic [2:0] code);
    case (code)
      3'b001:  decode = 3'd1;
      3'b011:  decode = 3'd2;
      3'b010:  decode = 3'd3;
      3'b110:  decode = 3'd4;
      3'b100:  decode = 3'd5;
      3'b101:  decode = 3'd6;
      default: decode = 3'd0;
    endcase
  endfunction

  // Input synchronizer chain; the oldest stage feeds the filter.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  sync_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], h};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce filter: a candidate must stay stable DEB_CYCLES samples and differ from the last accepted code.
  logic [2:0]       cand;
  logic [2:0]       last_code;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;

  assign accept_c = (cnt == CNT_MAX) && (cand != last_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= 3'b000;
      cnt       <= '0;
      last_code <= 3'b000;
    end else begin
      if (sync_out != cand) begin
        cand <= sync_out;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept_c) last_code <= cand;
    end
  end

  // Commutation period timer, saturating at TIMEOUT.
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] timer_d;

  always_comb begin
    if (accept_c)                timer_d = '0;
    else if (timer >= TIMEOUT_V) timer_d = TIMEOUT_V;
    else                         timer_d = timer + PERIOD_W'(1);
  end

  state_t              state;
  state_t              state_d;
  logic [2:0]          sector_d;
  logic [2:0]          new_sec;
  logic [2:0]          fwd_sec;
  logic [2:0]          rev_sec;
  logic                dir_d;
  logic                valid_d;
  logic                fault_d;
  logic                stb_d;
  logic                first;
  logic                first_d;
  logic [PERIOD_W-1:0] period_d;
  logic [15:0]         pos_d;

  // Next state and next output values; only an accepted code changes anything.
  always_comb begin
    state_d  = state;
    sector_d = sector;
    dir_d    = dir;
    valid_d  = valid;
    fault_d  = fault;
    period_d = period;
    stb_d    = 1'b0;
    pos_d    = pos;
    first_d  = first;
    new_sec  = decode(cand);
    fwd_sec  = (sector == 3'd6) ? 3'd1 : sector + 3'd1;
    rev_sec  = (sector == 3'd1) ? 3'd6 : sector - 3'd1;
    if (accept_c) begin
      case (state)
        S_TRACK: begin
          if (new_sec == fwd_sec || new_sec == rev_sec) begin
            sector_d = new_sec;
            dir_d    = (new_sec == fwd_sec);
            pos_d    = (new_sec == fwd_sec) ? pos + 16'd1 : pos - 16'd1;
            first_d  = 1'b0;
            // The timer holds cycles-1 just before the accepting edge.
            if (!stall && !first) begin
              period_d = timer + PERIOD_W'(1);
              stb_d    = 1'b1;
            end
          end else begin
            state_d  = S_FAULT;
            sector_d = 3'd0;
            valid_d  = 1'b0;
            fault_d  = 1'b1;
          end
        end
        default: begin
          if (new_sec != 3'd0) begin
            state_d  = S_TRACK;
            sector_d = new_sec;
            valid_d  = 1'b1;
            fault_d  = 1'b0;
            first_d  = 1'b1;
          end else begin
            state_d  = S_FAULT;
            sector_d = 3'd0;
            valid_d  = 1'b0;
            fault_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      sector     <= 3'd0;
      dir        <= 1'b1;
      valid      <= 1'b0;
      fault      <= 1'b0;
      stall      <= 1'b0;
      period     <= '0;
      period_stb <= 1'b0;
      pos        <= 16'd0;
      timer      <= '0;
      first      <= 1'b0;
    end else begin
      state      <= state_d;
      sector     <= sector_d;
      dir        <= dir_d;
      valid      <= valid_d;
      fault      <= fault_d;
      stall      <= (timer_d == TIMEOUT_V);
      period     <= period_d;
      period_stb <= stb_d;
      pos        <= pos_d;
      timer      <= timer_d;
      first      <= first_d;
    end
  end

endmodule
